// File: rtl/exe_wb_buffer.sv
// exe_wb_buffer: 2-entry in-order ALU result buffer with valid/ready writeback and operand forwarding
module exe_wb_buffer #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_result_i,
    input  logic [REG_ADDR_W-1:0] in_rd_i,
    input  logic                  in_we_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_result_o,
    output logic [REG_ADDR_W-1:0] out_rd_o,
    output logic                  out_we_o,
    input  logic [REG_ADDR_W-1:0] fwd_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] fwd_rs2_addr_i,
    output logic                  fwd_rs1_hit_o,
    output logic [DATA_W-1:0]     fwd_rs1_data_o,
    output logic                  fwd_rs2_hit_o,
    output logic [DATA_W-1:0]     fwd_rs2_data_o,
    output logic [1:0]            count_o
);
    logic [DATA_W-1:0]     res_q [2];
    logic [DATA_W-1:0]     res_d [2];
    logic [REG_ADDR_W-1:0] rd_q [2];
    logic [REG_ADDR_W-1:0] rd_d [2];
    logic [1:0]            we_q, we_d, vld_q, vld_d;
    logic                  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]            count_q, count_d;
    logic                  push, pop, in_we_eff;
    logic [2:0]            cand_v;

    assign in_ready_o   = count_q != 2'd2;
    assign out_valid_o  = count_q != 2'd0;
    assign out_result_o = out_valid_o ? res_q[rptr_q] : '0;
    assign out_rd_o     = out_valid_o ? rd_q[rptr_q] : '0;
    assign out_we_o     = out_valid_o && we_q[rptr_q];
    assign count_o      = count_q;
    assign push         = in_valid_i && in_ready_o;
    assign pop          = out_valid_o && out_ready_i;
    assign in_we_eff    = in_we_i && (in_rd_i != '0);

    always_comb begin
        res_d   = res_q;
        rd_d    = rd_q;
        we_d    = we_q;
        vld_d   = vld_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            res_d[wptr_q] = in_result_i;
            rd_d[wptr_q]  = in_rd_i;
            we_d[wptr_q]  = in_we_eff;
            vld_d[wptr_q] = 1'b1;
            wptr_d        = ~wptr_q;
        end
        if (pop) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = ~rptr_q;
        end
        if (flush_i) begin
            vld_d   = '0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            res_q   <= '{default: '0};
            rd_q    <= '{default: '0};
            we_q    <= '0;
            vld_q   <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            res_q   <= res_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            vld_q   <= vld_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Candidates youngest first: incoming, newest stored (wptr-1), oldest stored (rptr)
    assign cand_v = {vld_q[rptr_q] && we_q[rptr_q],
                     vld_q[~wptr_q] && we_q[~wptr_q],
                     push && !flush_i && in_we_eff};

    function automatic logic [DATA_W:0] lookup(
        input logic [REG_ADDR_W-1:0] a,
        input logic [2:0]            v,
        input logic [REG_ADDR_W-1:0] r0, r1, r2,
        input logic [DATA_W-1:0]     d0, d1, d2
    );
        lookup = (a == '0)           ? '0 :
                 (v[0] && r0 == a)   ? {1'b1, d0} :
                 (v[1] && r1 == a)   ? {1'b1, d1} :
                 (v[2] && r2 == a)   ? {1'b1, d2} : '0;
    endfunction

    assign {fwd_rs1_hit_o, fwd_rs1_data_o} = lookup(fwd_rs1_addr_i, cand_v,
        in_rd_i, rd_q[~wptr_q], rd_q[rptr_q], in_result_i, res_q[~wptr_q], res_q[rptr_q]);
    assign {fwd_rs2_hit_o, fwd_rs2_data_o} = lookup(fwd_rs2_addr_i, cand_v,
        in_rd_i, rd_q[~wptr_q], rd_q[rptr_q], in_result_i, res_q[~wptr_q], res_q[rptr_q]);
endmodule

// File: doc/exe_wb_buffer.md
Name: exe_wb_buffer

Overview:
- Execute-to-writeback buffer sitting directly downstream of the integer ALU.
- Captures each ALU result together with its destination register and write-enable into a 2-entry in-order FIFO.
- Presents the oldest entry to the register-file write port under a valid/ready handshake.
- Provides same-cycle operand forwarding of pending, not-yet-written results back to the operand-read logic feeding the ALU.

Parameters:
- DATA_W, 64, result and forwarded-data width.
- REG_ADDR_W, 5, architectural register index width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous discard of all buffered entries.
- in_valid_i  input  1  ALU result valid this cycle.
- in_ready_o  output  1  buffer can accept an entry.
- in_result_i  input  DATA_W  ALU result.
- in_rd_i  input  REG_ADDR_W  destination register.
- in_we_i  input  1  instruction writes rd.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  register file accepts head entry.
- out_result_o  output  DATA_W  head result.
- out_rd_o  output  REG_ADDR_W  head destination.
- out_we_o  output  1  head write-enable.
- fwd_rs1_addr_i  input  REG_ADDR_W  rs1 index to look up.
- fwd_rs2_addr_i  input  REG_ADDR_W  rs2 index to look up.
- fwd_rs1_hit_o  output  1  pending value exists for rs1.
- fwd_rs1_data_o  output  DATA_W  forwarded rs1 value.
- fwd_rs2_hit_o  output  1  pending value exists for rs2.
- fwd_rs2_data_o  output  DATA_W  forwarded rs2 value.
- count_o  output  2  occupied entries, 0..2.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - count=0, read and write pointers = 0, all entry valid bits cleared.
  - out_valid_o=0, out_result_o=0, out_rd_o=0, out_we_o=0, in_ready_o=1.
  - fwd hits 0, fwd data 0.
  - Reset asserted mid-handshake discards every entry; no write is emitted afterwards.
- Storage: 2-entry circular FIFO with 1-bit read and write pointers that wrap 1->0.
- Push: in_valid_i && in_ready_o.
  - Stores {result, rd, we_eff}, where we_eff = in_we_i && (in_rd_i != 0).
  - Entries with we_eff=0 are still stored and drained, preserving program order.
- Pop: out_valid_o && out_ready_i; advances the read pointer.
- in_ready_o = (count != 2). It is derived from registered state only; there is no combinational path from out_ready_i.
- Full with pop in the same cycle: no push is possible (in_ready_o=0); in_ready_o rises the next cycle.
- Push and pop in the same cycle with count=1: count stays 1, head moves to the new entry.
- Empty (count=0): out_valid_o=0 and out_result_o/out_rd_o/out_we_o driven to 0. A push into an empty buffer appears at the output the following cycle; latency is exactly 1 cycle, with no fall-through.
- Output stability: while out_valid_o=1 and out_ready_i=0, all out_* hold stable.
- count_o: registered; updates +1 on push-only, -1 on pop-only, unchanged on both or neither.
- flush_i:
  - Next cycle: count=0, pointers=0, out_valid_o=0.
  - Overrides a simultaneous push (the entry is dropped) and a simultaneous pop (the pop still counts as accepted by the consumer this cycle).
- Forwarding (combinational), evaluated per source independently. Candidates in priority order, youngest first:
  1. The in_ flow entry when in_valid_i && in_ready_o && !flush_i.
  2. The buffered entry at write pointer minus 1.
  3. The buffered entry at the read pointer.
  - A candidate hits when it is valid, we_eff=1, and its rd equals the lookup address.
  - Lookup address 0 never hits.
  - On hit, data = that candidate's result; otherwise data = 0.
- A stored entry remains a forwarding source during its pop cycle. It is no longer a source from the next cycle.
- Arithmetic: no transformation of result data; widths pass through unchanged.

Test Plan:
- Reset then idle -> count_o=0, in_ready_o=1, out_valid_o=0, all data outputs 0.
- Push {0x1234, rd=5, we=1} with out_ready_i=0 -> next cycle out_valid_o=1, out_result_o=0x1234, out_rd_o=5, out_we_o=1, count_o=1; outputs hold for 3 stall cycles.
- Push rd=3 value 0xA then rd=3 value 0xB, out_ready_i=0 -> count_o=2, in_ready_o=0; fwd_rs1_addr_i=3 gives hit=1, data=0xB; release out_ready_i -> writes drain in order 0xA then 0xB, in_ready_o=1 one cycle after the first pop.
- Push {0xFF, rd=0, we=1} -> entry emerges with out_we_o=0; fwd_rs2_addr_i=0 gives hit=0, data=0.
- Buffer holds rd=7 value 0x1; same cycle in_valid_i with rd=7 value 0x2 -> fwd for rd=7 gives 0x2; rs2 lookup rd=9 gives hit=0.
- count_o=2, assert flush_i together with in_valid_i -> next cycle count_o=0, out_valid_o=0, no forwarding hits; async reset during count_o=1 -> out_valid_o falls immediately, with no clock edge needed.
